// File: rtl/ps2_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ps2_pkg : shared constants and types for the PS/2 key encoder          |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package ps2_pkg;

  localparam logic [7:0] C_PFX_EXT   = 8'hE0;
  localparam logic [7:0] C_PFX_BRK   = 8'hF0;
  localparam logic [7:0] C_PFX_PAUSE = 8'hE1;
  localparam logic [7:0] C_BAT_OK    = 8'hAA;
  localparam logic [7:0] C_ACK       = 8'hFA;
  localparam logic [7:0] C_RESEND    = 8'hFE;
  localparam logic [7:0] C_ECHO      = 8'hEE;
  localparam logic [7:0] C_ERR_00    = 8'h00;
  localparam logic [7:0] C_ERR_FF    = 8'hFF;

  localparam int KEY_TOGGLE  = 10;
  localparam int KEY_PRESSED = 9;
  localparam int KEY_EXT     = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_e;

  // Keyboard housekeeping bytes that never describe a key.
  function automatic logic is_ignore_byte(input logic [7:0] b);
    return (b == C_BAT_OK) || (b == C_ACK) || (b == C_RESEND) ||
           (b == C_ECHO) || (b == C_ERR_00) || (b == C_ERR_FF);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_key_encoder_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ps2_key_encoder_if : PS/2 pins and key-event outputs                   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface ps2_key_encoder_if;
  logic        I_PS2_CLK;
  logic        I_PS2_DAT;
  logic [10:0] O_PS2_KEY;
  logic        O_FRAME_ERR;
  logic        O_BUSY;

  modport master (
    output I_PS2_CLK, I_PS2_DAT,
    input  O_PS2_KEY, O_FRAME_ERR, O_BUSY
  );

  modport slave (
    input  I_PS2_CLK, I_PS2_DAT,
    output O_PS2_KEY, O_FRAME_ERR, O_BUSY
  );
endinterface
`default_nettype wire

// File: rtl/ps2_rx_byte.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ps2_rx_byte : sync, clock glitch filter, 11-bit frame FSM, timeout     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module ps2_rx_byte
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 24576
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_dat,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int FCNT_W = $clog2(FILTER_LEN + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FCNT_W-1:0] C_FILT_LAST = FCNT_W'(FILTER_LEN - 1);
  localparam logic [TO_W-1:0]   C_TO_LAST   = TO_W'(TIMEOUT_CYC - 1);

  logic [1:0]        clk_sync_q, clk_sync_d;
  logic [1:0]        dat_sync_q, dat_sync_d;
  logic              filt_q, filt_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  frame_state_e      state_q, state_d;
  logic [2:0]        bitcnt_q, bitcnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              par_q, par_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              byte_valid_q, byte_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              strobe_w;
  logic              sample_w;
  logic              timeout_w;

  assign clk_sync_d = {clk_sync_q[0], i_ps2_clk};
  assign dat_sync_d = {dat_sync_q[0], i_ps2_dat};
  assign sample_w   = dat_sync_q[1];

  // Level flips only after FILTER_LEN consecutive samples disagree with it.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_sync_q[1] != filt_q) begin
      if (fcnt_q == C_FILT_LAST) begin
        filt_d = clk_sync_q[1];
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  assign strobe_w  = filt_q & ~filt_d;
  assign timeout_w = (state_q != ST_IDLE) && (to_cnt_q == C_TO_LAST);

  always_comb begin
    state_d      = state_q;
    bitcnt_d     = bitcnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    to_cnt_d     = (state_q == ST_IDLE || strobe_w) ? '0 : to_cnt_q + 1'b1;

    // Timeout takes priority over a coincident strobe, whose bit is dropped.
    if (timeout_w) begin
      state_d     = ST_IDLE;
      frame_err_d = 1'b1;
      to_cnt_d    = '0;
    end else if (strobe_w) begin
      case (state_q)
        ST_IDLE: begin
          if (!sample_w) begin
            state_d  = ST_DATA;
            bitcnt_d = 3'd0;
          end
        end
        ST_DATA: begin
          shift_d  = {sample_w, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end
        end
        ST_PARITY: begin
          par_d   = sample_w;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          if (sample_w && ((^shift_q) ^ par_q)) begin
            byte_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q   <= 2'b11;
      dat_sync_q   <= 2'b11;
      filt_q       <= 1'b1;
      fcnt_q       <= '0;
      state_q      <= ST_IDLE;
      bitcnt_q     <= 3'd0;
      shift_q      <= 8'h00;
      par_q        <= 1'b0;
      to_cnt_q     <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      clk_sync_q   <= clk_sync_d;
      dat_sync_q   <= dat_sync_d;
      filt_q       <= filt_d;
      fcnt_q       <= fcnt_d;
      state_q      <= state_d;
      bitcnt_q     <= bitcnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      to_cnt_q     <= to_cnt_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign o_byte       = shift_q;
  assign o_byte_valid = byte_valid_q;
  assign o_frame_err  = frame_err_q;
  assign o_busy       = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: rtl/ps2_key_encoder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ps2_key_encoder : PS/2 bytes -> 11-bit toggle/pressed/ext/code event   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module ps2_key_encoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 24576,
  parameter int E1_SKIP     = 7
) (
  input  logic              I_CLK_24576M,
  input  logic              I_RESETn,
  ps2_key_encoder_if.slave  bus
);

  localparam int SKIP_W = $clog2(E1_SKIP + 1);
  localparam logic [SKIP_W-1:0] C_SKIP_INIT = SKIP_W'(E1_SKIP);

  logic [7:0]        rx_byte_w;
  logic              rx_valid_w;
  logic              rx_err_w;
  logic              rx_busy_w;
  logic [10:0]       key_q, key_d;
  logic              brk_q, brk_d;
  logic              ext_q, ext_d;
  logic [SKIP_W-1:0] skip_q, skip_d;

  ps2_rx_byte #(
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_rx (
    .clk          (I_CLK_24576M),
    .rst_n        (I_RESETn),
    .i_ps2_clk    (bus.I_PS2_CLK),
    .i_ps2_dat    (bus.I_PS2_DAT),
    .o_byte       (rx_byte_w),
    .o_byte_valid (rx_valid_w),
    .o_frame_err  (rx_err_w),
    .o_busy       (rx_busy_w)
  );

  // Data bits and the toggle bit are committed together in one register write.
  always_comb begin
    key_d  = key_q;
    brk_d  = brk_q;
    ext_d  = ext_q;
    skip_d = skip_q;
    if (rx_valid_w) begin
      if (skip_q != '0) begin
        skip_d = skip_q - 1'b1;
      end else if (rx_byte_w == C_PFX_PAUSE) begin
        skip_d = C_SKIP_INIT;
        brk_d  = 1'b0;
        ext_d  = 1'b0;
      end else if (rx_byte_w == C_PFX_EXT) begin
        ext_d = 1'b1;
      end else if (rx_byte_w == C_PFX_BRK) begin
        brk_d = 1'b1;
      end else if (is_ignore_byte(rx_byte_w)) begin
        brk_d = 1'b0;
        ext_d = 1'b0;
      end else begin
        key_d[KEY_TOGGLE]  = ~key_q[KEY_TOGGLE];
        key_d[KEY_PRESSED] = ~brk_q;
        key_d[KEY_EXT]     = ext_q;
        key_d[7:0]         = rx_byte_w;
        brk_d              = 1'b0;
        ext_d              = 1'b0;
      end
    end
  end

  always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
    if (!I_RESETn) begin
      key_q  <= 11'd0;
      brk_q  <= 1'b0;
      ext_q  <= 1'b0;
      skip_q <= '0;
    end else begin
      key_q  <= key_d;
      brk_q  <= brk_d;
      ext_q  <= ext_d;
      skip_q <= skip_d;
    end
  end

  assign bus.O_PS2_KEY   = key_q;
  assign bus.O_FRAME_ERR = rx_err_w;
  assign bus.O_BUSY      = rx_busy_w;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_encoder.sv
`default_nettype none
`timescale 1ns/1ps
// +-----------------------------------------------------------------------+
// | tb_ps2_key_encoder : directed PS/2 frames with a key-event scoreboard  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_ps2_key_encoder;

  localparam int TIMEOUT  = 2000;
  localparam int HALF_BIT = 20;

  logic clk = 1'b0;
  logic rst_n;
  always #20.345 clk = ~clk;

  ps2_key_encoder_if bus_if ();

  ps2_key_encoder #(
    .FILTER_LEN  (8),
    .TIMEOUT_CYC (TIMEOUT),
    .E1_SKIP     (7)
  ) dut (
    .I_CLK_24576M (clk),
    .I_RESETn     (rst_n),
    .bus          (bus_if)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [10:0] exp_q[$];
  logic        exp_tog  = 1'b0;
  logic [10:0] last_exp = 11'd0;
  int          err_seen = 0;
  logic        busy_seen = 1'b0;
  logic        prev_tog  = 1'b0;
  int          cycle     = 0;
  int          last_err_cycle  = 0;
  int          last_fall_cycle = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic push_key(input logic pressed, input logic ext, input logic [7:0] code);
    exp_tog  = ~exp_tog;
    last_exp = {exp_tog, pressed, ext, code};
    exp_q.push_back(last_exp);
  endtask

  // Start, 8 data LSB first, odd parity (optionally inverted), stop.
  task automatic send_frame(input logic [7:0] b, input bit flip_par, input int nbits);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ flip_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      bus_if.I_PS2_DAT = fr[i];
      repeat (HALF_BIT) @(posedge clk);
      bus_if.I_PS2_CLK = 1'b0;
      last_fall_cycle  = cycle;
      repeat (HALF_BIT) @(posedge clk);
      bus_if.I_PS2_CLK = 1'b1;
    end
    bus_if.I_PS2_DAT = 1'b1;
    if (nbits == 11) repeat (2 * HALF_BIT) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b0, 11);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 400) begin
      @(posedge clk);
      k++;
    end
    check({name, "_drain"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Monitor: every toggle of bit 10 is one key event checked against the queue.
  initial begin
    logic [10:0] e;
    forever begin
      @(negedge clk);
      cycle++;
      if (!rst_n) begin
        prev_tog = bus_if.O_PS2_KEY[10];
      end else begin
        if (bus_if.O_FRAME_ERR) begin
          err_seen++;
          last_err_cycle = cycle;
        end
        if (bus_if.O_BUSY) busy_seen = 1'b1;
        if (bus_if.O_PS2_KEY[10] != prev_tog) begin
          prev_tog = bus_if.O_PS2_KEY[10];
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got %h, required no event", bus_if.O_PS2_KEY);
          end else begin
            e = exp_q.pop_front();
            if (bus_if.O_PS2_KEY !== e) begin
              n_fail++;
              $display("FAIL key_event: got %h, required %h", bus_if.O_PS2_KEY, e);
            end
          end
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout, required completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int k;
    logic [7:0]  pause_seq [8];
    logic [10:0] snap;
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

    bus_if.I_PS2_CLK = 1'b1;
    bus_if.I_PS2_DAT = 1'b1;
    rst_n = 1'b1;
    #5 rst_n = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("reset_key", bus_if.O_PS2_KEY, 0);
    check("reset_err", bus_if.O_FRAME_ERR, 0);
    check("reset_busy", bus_if.O_BUSY, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(posedge clk);

    push_key(1'b1, 1'b0, 8'h29);
    send_byte(8'h29);
    drain("space");

    push_key(1'b0, 1'b0, 8'h29);
    send_byte(8'hF0); send_byte(8'h29);
    drain("space_break");

    push_key(1'b1, 1'b1, 8'h75);
    send_byte(8'hE0); send_byte(8'h75);
    push_key(1'b0, 1'b1, 8'h75);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    push_key(1'b0, 1'b1, 8'h74);
    send_byte(8'hF0); send_byte(8'hE0); send_byte(8'h74);
    drain("ext_keys");

    e0 = err_seen;
    send_frame(8'h72, 1'b1, 11);
    check("parity_err_pulse", err_seen, e0 + 1);
    check("parity_key_hold", bus_if.O_PS2_KEY, last_exp);
    push_key(1'b1, 1'b0, 8'h72);
    send_byte(8'h72);
    drain("after_parity");

    e0 = err_seen;
    send_frame(8'h6B, 1'b0, 4);
    k = 0;
    while (err_seen == e0 && k < 3 * TIMEOUT) begin
      @(posedge clk);
      k++;
    end
    check("timeout_pulse", err_seen, e0 + 1);
    check("timeout_window",
          ((last_err_cycle - last_fall_cycle) >= TIMEOUT) &&
          ((last_err_cycle - last_fall_cycle) <= TIMEOUT + 30), 1);
    #1;
    check("timeout_busy", bus_if.O_BUSY, 0);
    repeat (10) @(posedge clk);
    push_key(1'b1, 1'b0, 8'h6B);
    send_byte(8'h6B);
    drain("after_timeout");

    for (int i = 0; i < 8; i++) send_byte(pause_seq[i]);
    push_key(1'b1, 1'b0, 8'h05);
    send_byte(8'h05);
    drain("pause");

    busy_seen = 1'b0;
    snap = bus_if.O_PS2_KEY;
    for (int i = 0; i < 4; i++) begin
      bus_if.I_PS2_CLK = 1'b0;
      repeat (3) @(posedge clk);
      bus_if.I_PS2_CLK = 1'b1;
      repeat (12) @(posedge clk);
    end
    repeat (20) @(posedge clk);
    check("glitch_busy", busy_seen, 0);
    check("glitch_key", bus_if.O_PS2_KEY, snap);
    push_key(1'b1, 1'b0, 8'h1C);
    send_byte(8'h1C);
    drain("after_glitch");

    send_frame(8'h33, 1'b0, 5);
    repeat (3) @(posedge clk);
    #7 rst_n = 1'b0;
    #1;
    check("midreset_key", bus_if.O_PS2_KEY, 0);
    check("midreset_err", bus_if.O_FRAME_ERR, 0);
    check("midreset_busy", bus_if.O_BUSY, 0);
    exp_tog = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(posedge clk);
    push_key(1'b1, 1'b0, 8'h4A);
    send_byte(8'h4A);
    drain("after_reset");

    check("total_errors", err_seen, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
